// File: rtl/riscv_alu_exec.sv
// Execute unit for ALU ops with valid/ready handshakes; shifts iterate one bit per cycle.
// Define RISCV_ALU_EXEC_FAST_SHIFT_EN to use a single-cycle barrel shifter instead.
module riscv_alu_exec #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3:0]          alu_ctrl,
   input  logic [XLEN-1:0]     op_a,
   input  logic [XLEN-1:0]     op_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     result,
   output logic                zero,
   output logic                illegal
);

   localparam logic [3:0] CtrlAdd = 4'b0000;
   localparam logic [3:0] CtrlSub = 4'b0001;
   localparam logic [3:0] CtrlAnd = 4'b0010;
   localparam logic [3:0] CtrlOr  = 4'b0011;
   localparam logic [3:0] CtrlSll = 4'b0101;
   localparam logic [3:0] CtrlSrl = 4'b0110;
   localparam logic [3:0] CtrlSra = 4'b0111;
   localparam logic [3:0] CtrlSlt = 4'b1000;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              zero_q, zero_d;
   logic              illegal_q, illegal_d;
   logic [SHAMT_W-1:0] shamt;
   logic              accept;

`ifndef RISCV_ALU_EXEC_FAST_SHIFT_EN
   typedef enum logic [1:0] {ShSll, ShSrl, ShSra} shift_e;

   shift_e             kind_q, kind_d;
   logic [SHAMT_W-1:0] count_q, count_d;
   logic [XLEN-1:0]    shift_one;

   // Single-bit step of the iterative shifter; result_q doubles as the working register.
   always_comb begin
      shift_one = result_q;
      unique case (kind_q)
         ShSll:   shift_one = {result_q[XLEN-2:0], 1'b0};
         ShSrl:   shift_one = {1'b0, result_q[XLEN-1:1]};
         ShSra:   shift_one = {result_q[XLEN-1], result_q[XLEN-1:1]};
         default: shift_one = result_q;
      endcase
   end
`endif

   assign shamt     = op_b[SHAMT_W-1:0];
   // Gated with rst_n so nothing is accepted while reset is held.
   assign in_ready  = (state_q == StIdle) && rst_n;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == StDone);
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
`ifndef RISCV_ALU_EXEC_FAST_SHIFT_EN
      kind_d    = kind_q;
      count_d   = count_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d   = StDone;
               illegal_d = 1'b0;
               case (alu_ctrl)
                  CtrlAdd: result_d = op_a + op_b;
                  CtrlSub: result_d = op_a - op_b;
                  CtrlAnd: result_d = op_a & op_b;
                  CtrlOr:  result_d = op_a | op_b;
                  CtrlSlt: result_d = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
`ifdef RISCV_ALU_EXEC_FAST_SHIFT_EN
                  CtrlSll: result_d = op_a << shamt;
                  CtrlSrl: result_d = op_a >> shamt;
                  CtrlSra: result_d = XLEN'($signed(op_a) >>> shamt);
`else
                  CtrlSll, CtrlSrl, CtrlSra: begin
                     result_d = op_a;
                     count_d  = shamt;
                     kind_d   = (alu_ctrl == CtrlSll) ? ShSll :
                                (alu_ctrl == CtrlSrl) ? ShSrl : ShSra;
                     if (shamt != '0) begin
                        state_d = StShift;
                     end
                  end
`endif
                  default: begin
                     result_d  = '0;
                     illegal_d = 1'b1;
                  end
               endcase
               zero_d = (result_d == '0);
            end
         end
         StShift: begin
`ifndef RISCV_ALU_EXEC_FAST_SHIFT_EN
            result_d = shift_one;
            count_d  = count_q - SHAMT_W'(1);
            if (count_q == SHAMT_W'(1)) begin
               state_d = StDone;
               zero_d  = (shift_one == '0);
            end
`else
            state_d = StIdle;
`endif
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
`ifndef RISCV_ALU_EXEC_FAST_SHIFT_EN
         kind_q    <= ShSll;
         count_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
`ifndef RISCV_ALU_EXEC_FAST_SHIFT_EN
         kind_q    <= kind_d;
         count_q   <= count_d;
`endif
      end
   end

endmodule

// File: tb/tb_riscv_alu_exec.sv
// Table-driven self-checking bench for riscv_alu_exec with an expected-result scoreboard.
module tb_riscv_alu_exec;

`ifdef RISCV_ALU_EXEC_FAST_SHIFT_EN
   localparam bit Fast = 1'b1;
`else
   localparam bit Fast = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_ctrl;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int cyc   = 0;
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   riscv_alu_exec #(.XLEN(32), .SHAMT_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic        ill;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        ill;
      int          lat;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] r, input logic z, input logic ill);
      vec_t v;
      v.ctrl = c; v.a = a; v.b = b; v.res = r; v.z = z; v.ill = ill;
      return v;
   endfunction

   function automatic int exp_latency(input logic [3:0] c, input logic [31:0] b);
      bit is_shift;
      is_shift = (c == 4'b0101) || (c == 4'b0110) || (c == 4'b0111);
      if (Fast || !is_shift) return 1;
      return 1 + int'(b[4:0]);
   endfunction

   task automatic issue(input vec_t v, output int t_acc);
      exp_t e;
      int   w;
      w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("in_ready_before_issue", in_ready, 1'b1);
      in_valid = 1'b1;
      alu_ctrl = v.ctrl;
      op_a     = v.a;
      op_b     = v.b;
      @(posedge clk);
      #1;
      t_acc = cyc;
      e.res = v.res; e.z = v.z; e.ill = v.ill; e.lat = exp_latency(v.ctrl, v.b);
      sb.push_back(e);
      // Scramble inputs after acceptance; the in-flight op must not see them.
      in_valid = 1'b0;
      alu_ctrl = 4'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
   endtask

   task automatic collect(input int t_acc, input int hold, input string name);
      exp_t        e;
      int          waited;
      logic [31:0] held;
      waited = 0;
      @(negedge clk);
      while (!out_valid && waited < 100) begin
         check({name, "_busy_in_ready"}, in_ready, 1'b0);
         @(negedge clk);
         waited++;
      end
      if (sb.size() == 0) begin
         check({name, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      if (!out_valid) begin
         check({name, "_timeout_out_valid"}, out_valid, 1'b1);
         return;
      end
      check({name, "_latency"}, 32'(cyc - t_acc + 1), 32'(e.lat));
      check({name, "_result"}, result, e.res);
      check({name, "_zero"}, zero, e.z);
      check({name, "_illegal"}, illegal, e.ill);
      held = result;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({name, "_hold_valid"}, out_valid, 1'b1);
         check({name, "_hold_result"}, result, held);
         check({name, "_hold_in_ready"}, in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_drain_valid"}, out_valid, 1'b0);
      check({name, "_drain_in_ready"}, in_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int   t;
      vec_t v;

      vecs[0]  = mk(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
      vecs[1]  = mk(4'b0000, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0);
      vecs[2]  = mk(4'b0001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0);
      vecs[3]  = mk(4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
      vecs[4]  = mk(4'b0010, 32'hF0F0_FF00, 32'h0FF0_0FF0, 32'h00F0_0F00, 1'b0, 1'b0);
      vecs[5]  = mk(4'b0011, 32'hF0F0_0000, 32'h0000_1234, 32'hF0F0_1234, 1'b0, 1'b0);
      vecs[6]  = mk(4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
      vecs[7]  = mk(4'b1000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
      vecs[8]  = mk(4'b1000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      vecs[9]  = mk(4'b0111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0);
      vecs[10] = mk(4'b0110, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0);
      vecs[11] = mk(4'b0101, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0);
      vecs[12] = mk(4'b0101, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0);
      vecs[13] = mk(4'b0111, 32'h7000_0000, 32'h0000_0003, 32'h0E00_0000, 1'b0, 1'b0);
      vecs[14] = mk(4'b0110, 32'hF000_000F, 32'h0000_0124, 32'h0F00_0000, 1'b0, 1'b0);
      vecs[15] = mk(4'b0100, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1);
      vecs[16] = mk(4'b1111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1);
      vecs[17] = mk(4'b0101, 32'h0000_0003, 32'hFFFF_FFE1, 32'h0000_0006, 1'b0, 1'b0);
      vecs[18] = mk(4'b0111, 32'h8000_0001, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b0);

      // Reset with a pending request: nothing may be accepted.
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      alu_ctrl  = 4'b0000;
      op_a      = 32'h0000_0001;
      op_b      = 32'h0000_0002;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("reset_out_valid", out_valid, 1'b0);
         check("reset_result", result, 32'h0);
         check("reset_zero", zero, 1'b0);
         check("reset_illegal", illegal, 1'b0);
         check("reset_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      rst_n    = 1'b1;
      #1;
      check("post_reset_in_ready", in_ready, 1'b1);
      check("post_reset_out_valid", out_valid, 1'b0);

      for (int i = 0; i < 19; i++) begin
         issue(vecs[i], t);
         collect(t, 0, $sformatf("vec%0d", i));
      end

      // Backpressure: result must hold for 5 cycles with out_ready low.
      v = mk(4'b0001, 32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b0);
      issue(v, t);
      collect(t, 5, "backpressure");
      v = mk(4'b0111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0);
      issue(v, t);
      collect(t, 3, "bp_shift");

      // Abort: reset during a long shift drops the operation.
      v = mk(4'b0101, 32'h0000_0001, 32'h0000_0014, 32'h0010_0000, 1'b0, 1'b0);
      issue(v, t);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("abort_pre_out_valid", out_valid, Fast);
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_rst_out_valid", out_valid, 1'b0);
      check("abort_rst_in_ready", in_ready, 1'b0);
      rst_n = 1'b1;
      void'(sb.pop_front());
      #1;
      check("abort_release_in_ready", in_ready, 1'b1);
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         check("abort_post_out_valid", out_valid, 1'b0);
      end
      check("abort_idle_in_ready", in_ready, 1'b1);

      issue(vecs[1], t);
      collect(t, 0, "after_abort");
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
